// File: rtl/mdu_iter_pkg.sv
// Shared constants for the iterative multiply/divide unit: M-extension
// funct3 encodings, controller state type and operand-signedness helpers.
package mdu_iter_pkg;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } mdu_state_e;

  // op_a is interpreted as two's complement for these ops
  function automatic logic mdu_a_signed(input logic [2:0] f);
    return (f == MDU_MULH) || (f == MDU_MULHSU) || (f == MDU_DIV) || (f == MDU_REM);
  endfunction

  // op_b is interpreted as two's complement for these ops
  function automatic logic mdu_b_signed(input logic [2:0] f);
    return (f == MDU_MULH) || (f == MDU_DIV) || (f == MDU_REM);
  endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One iteration of the unsigned magnitude datapath.
//   i_div : 1 = restoring shift-subtract step, 0 = shift-add step
//   i_acc : high half (partial product / partial remainder)
//   i_lo  : low half (multiplier bits / dividend-quotient bits)
//   i_md  : multiplicand or divisor magnitude
//   o_acc, o_lo : updated halves after one step
module mdu_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_div,
  input  logic [XLEN-1:0] i_acc,
  input  logic [XLEN-1:0] i_lo,
  input  logic [XLEN-1:0] i_md,
  output logic [XLEN-1:0] o_acc,
  output logic [XLEN-1:0] o_lo
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_rem_sh;
  logic [XLEN:0] w_diff;

  always_comb begin
    // multiply: conditionally add, then shift {carry,acc,lo} right one place
    w_sum    = {1'b0, i_acc} + (i_lo[0] ? {1'b0, i_md} : '0);
    // divide: shift next dividend bit into the remainder, trial subtract;
    // bit XLEN of the difference is the borrow
    w_rem_sh = {i_acc, i_lo[XLEN-1]};
    w_diff   = w_rem_sh - {1'b0, i_md};
    if (i_div) begin
      if (!w_diff[XLEN]) begin
        o_acc = w_diff[XLEN-1:0];
        o_lo  = {i_lo[XLEN-2:0], 1'b1};
      end else begin
        o_acc = w_rem_sh[XLEN-1:0];
        o_lo  = {i_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      o_acc = w_sum[XLEN:1];
      o_lo  = {w_sum[0], i_lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RISC-V M-extension multiply/divide unit. Operands are reduced to
// magnitudes plus a result-sign flag at accept, iterated XLEN times through
// mdu_step, and the sign is fixed up on the CALC->DONE edge.
//   clk, rst_n          : clock, async active-low reset
//   flush               : abort any operation, return to IDLE
//   in_valid/in_ready   : request handshake (funct3, op_a, op_b)
//   out_valid/out_ready : result handshake (result)
//   busy                : controller not in IDLE
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e        r_state, w_next;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_op;
  logic              r_neg;
  logic [XLEN-1:0]   r_acc, r_lo, r_md, r_result;

  logic              w_accept, w_a_neg, w_b_neg, w_neg, w_div_zero, w_ovf, w_skip;
  logic [XLEN-1:0]   w_a_mag, w_b_mag, w_special, w_step_acc, w_step_lo;
  logic [XLEN-1:0]   w_quo, w_rem, w_final;
  logic [2*XLEN-1:0] w_prod;

  assign w_accept   = in_valid && (r_state == ST_IDLE) && !flush;
  assign w_a_neg    = mdu_a_signed(funct3) && op_a[XLEN-1];
  assign w_b_neg    = mdu_b_signed(funct3) && op_b[XLEN-1];
  assign w_a_mag    = w_a_neg ? -op_a : op_a;
  assign w_b_mag    = w_b_neg ? -op_b : op_b;
  // remainder takes the dividend's sign; everything else the XOR of both
  assign w_neg      = (funct3 == MDU_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);
  assign w_div_zero = funct3[2] && (op_b == '0);
  assign w_ovf      = ((funct3 == MDU_DIV) || (funct3 == MDU_REM)) &&
                      (op_a == MOST_NEG) && (op_b == '1);
  assign w_skip     = w_div_zero || w_ovf;
  // funct3[1] selects the remainder form among the divide ops
  assign w_special  = w_div_zero ? (funct3[1] ? op_a : '1)
                                 : (funct3[1] ? '0 : op_a);

  mdu_step #(.XLEN(XLEN)) u_step (
    .i_div (r_op[2]),
    .i_acc (r_acc),
    .i_lo  (r_lo),
    .i_md  (r_md),
    .o_acc (w_step_acc),
    .o_lo  (w_step_lo)
  );

  // sign fixup: MULH* need the full 2*XLEN negation, not just the high half
  always_comb begin
    w_prod = r_neg ? -{r_acc, r_lo} : {r_acc, r_lo};
    w_quo  = r_neg ? -r_lo : r_lo;
    w_rem  = r_neg ? -r_acc : r_acc;
    case (r_op)
      MDU_MUL:                        w_final = w_prod[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: w_final = w_prod[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:              w_final = w_quo;
      default:                        w_final = w_rem;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = w_skip ? ST_DONE : ST_CALC;
      ST_CALC: if (r_cnt == '0) w_next = ST_DONE;
      ST_DONE: if (out_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    if (flush) w_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_op     <= MDU_MUL;
      r_neg    <= 1'b0;
      r_acc    <= '0;
      r_lo     <= '0;
      r_md     <= '0;
      r_result <= '0;
    end else if (flush) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_op  <= funct3;
          r_neg <= w_neg;
          r_acc <= '0;
          if (w_skip) begin
            r_result <= w_special;
            r_cnt    <= '0;
          end else begin
            r_cnt <= CW'(XLEN);
            // mul: lo = multiplier, md = multiplicand; div: lo = dividend, md = divisor
            r_lo  <= funct3[2] ? w_a_mag : w_b_mag;
            r_md  <= funct3[2] ? w_b_mag : w_a_mag;
          end
        end
        ST_CALC: begin
          if (r_cnt == '0) begin
            r_result <= w_final;
          end else begin
            r_acc <= w_step_acc;
            r_lo  <= w_step_lo;
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);
  assign result    = r_result;

endmodule

// File: tb/tb_mdu_iter.sv
module tb_mdu_iter;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2:0]      funct3 = 3'b000;
  logic [XLEN-1:0] op_a = '0;
  logic [XLEN-1:0] op_b = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] result;
  logic            busy;

  int n_pass = 0;
  int n_total = 0;

  mdu_iter #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .funct3    (funct3),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference: plain arithmetic on 64-bit / signed integers
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    ia = a;
    ib = b;
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 0) return 0;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return XLEN + 1;
  endfunction

  // Present a request before the next edge; returns after the accept edge (+1ns)
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    funct3 = f;
    op_a = a;
    op_b = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // scramble request inputs while busy; must have no effect
    funct3 = 3'($urandom_range(0, 7));
    op_a = $urandom;
    op_b = $urandom;
  endtask

  task automatic wait_result(input string name, input logic [31:0] exp, input int exp_lat);
    int lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({name, "_res"}, 64'(result), 64'(exp));
  endtask

  task automatic release_result(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({name, "_idle"}, {63'b0, in_ready & ~out_valid & ~busy}, 64'd1);
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33});
    vecs.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33});
    vecs.push_back('{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33});
    vecs.push_back('{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33});
    vecs.push_back('{3'd5, 32'h0000_0007, 32'h0000_0002, 32'h0000_0003, 33});
    vecs.push_back('{3'd7, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 33});
    vecs.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33});
    vecs.push_back('{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33});
    vecs.push_back('{3'd5, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 0});
    vecs.push_back('{3'd6, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 0});
    vecs.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0});
    vecs.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0});

    // reset values while held in reset
    #12;
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed table
    foreach (vecs[i]) begin
      issue(vecs[i].f, vecs[i].a, vecs[i].b);
      wait_result($sformatf("vec%0d", i), vecs[i].exp, vecs[i].lat);
      release_result($sformatf("vec%0d", i));
    end

    // random against model, with biased corner operands
    for (int i = 0; i < 40; i++) begin
      logic [2:0] f;
      logic [31:0] a, b;
      int mode;
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      mode = $urandom_range(0, 7);
      if (mode == 0) b = '0;
      else if (mode == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (mode == 2) b = 32'($urandom_range(1, 15));
      issue(f, a, b);
      wait_result($sformatf("rnd%0d", i), model(f, a, b), model_lat(f, a, b));
      release_result($sformatf("rnd%0d", i));
    end

    // hold in DONE with out_ready low; a pending request must not be taken
    issue(3'd0, 32'd3, 32'd5);
    wait_result("hold", 32'd15, 33);
    @(negedge clk);
    in_valid = 1'b1;
    funct3 = 3'd5;
    op_a = 32'd100;
    op_b = 32'd7;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold%0d_ov", c), {63'b0, out_valid}, 64'd1);
      chk($sformatf("hold%0d_res", c), 64'(result), 64'd15);
      chk($sformatf("hold%0d_ir", c), {63'b0, in_ready}, 64'd0);
    end
    in_valid = 1'b0;
    release_result("hold");

    // flush at edge 10 of a MUL; request held through flush, accepted at edge 11
    issue(3'd0, 32'd1234, 32'd5678);
    repeat (8) @(posedge clk);       // edges 2..9 (issue already passed edge 1 region)
    @(negedge clk);
    flush = 1'b1;
    in_valid = 1'b1;
    funct3 = 3'd5;
    op_a = 32'd100;
    op_b = 32'd7;
    @(posedge clk);
    #1;
    chk("flush_busy", {63'b0, busy}, 64'd0);
    chk("flush_in_ready", {63'b0, in_ready}, 64'd1);
    chk("flush_out_valid", {63'b0, out_valid}, 64'd0);
    flush = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("flush_reaccept", {63'b0, busy}, 64'd1);
    wait_result("post_flush", 32'd14, 33);
    release_result("post_flush");

    // asynchronous reset mid-CALC
    issue(3'd4, 32'hFFFF_FF00, 32'd3);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {63'b0, busy}, 64'd0);
    chk("arst_in_ready", {63'b0, in_ready}, 64'd1);
    chk("arst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("arst_result", 64'(result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen = 0;
      for (int c = 0; c < 40; c++) begin
        @(posedge clk);
        #1;
        if (out_valid || busy) seen++;
      end
      chk("arst_no_stale", 64'(seen), 64'd0);
    end
    issue(3'd6, 32'hFFFF_FF9C, 32'd7);
    wait_result("post_rst", model(3'd6, 32'hFFFF_FF9C, 32'd7), 33);
    release_result("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving operand and result width (any even value >= 8).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port flush  input  1  abort the current operation (pipeline kill).
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port funct3  input  3  M-extension op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 SHALL have ports op_a, op_b  input  XLEN  rs1 and rs2 operands.
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result.
REQ-011 SHALL have port result  output  XLEN  operation result.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement states IDLE, CALC, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-014 SHALL accept a request on a rising edge with in_valid & in_ready & !flush, latching funct3 and operand magnitudes with sign flags.
REQ-015 SHALL, on a normal accept, enter CALC with counter = XLEN and perform one shift-add (mul) or one restoring shift-subtract (div) step per CALC cycle.
REQ-016 SHALL move CALC->DONE on the edge where the counter reaches 0; for an accept at edge 0, out_valid SHALL rise after edge XLEN+1.
REQ-017 SHALL apply the sign correction (two's-complement negation) on the CALC->DONE edge; result is registered and stable throughout DONE.
REQ-018 SHALL compute a 2*XLEN product: MUL returns low XLEN bits; MULH signed x signed, MULHSU signed op_a x unsigned op_b, MULHU unsigned x unsigned, each returning the high XLEN bits.
REQ-019 SHALL, for DIV/REM, round the quotient toward zero; the quotient sign is sign(a) XOR sign(b); the remainder sign is sign(a).
REQ-020 SHALL, for divide by zero (op_b==0), skip CALC and go IDLE->DONE on the accept edge with quotient all-ones and remainder op_a, for both signed and unsigned forms.
REQ-021 SHALL, for signed overflow (DIV/REM, op_a = most-negative value, op_b = all-ones), skip CALC with quotient op_a and remainder 0.
REQ-022 SHALL leave DONE to IDLE on an edge with out_ready=1; with out_ready=0 it SHALL hold DONE and result indefinitely.
REQ-023 SHALL not accept a new request in the DONE->IDLE cycle, so there is no back-to-back bypass; the next accept occurs at the earliest one cycle later.
REQ-024 SHALL, when flush=1 on an edge, go to IDLE from any state, drop any pending result, and ignore a simultaneous in_valid.
REQ-025 SHALL ignore funct3 and operand changes while busy.

Reset
REQ-026 SHALL, while rst_n=0, immediately force state IDLE, counter 0, result 0, out_valid 0, busy 0, in_ready 1.
REQ-027 SHALL discard an in-flight operation on reset mid-CALC or mid-DONE; no out_valid SHALL appear after release.

Structure
REQ-028 SHALL take the funct3 op encodings (MDU_MUL ... MDU_REMU) and the state enum from the shared constants package (Constants), not local literals.
REQ-029 SHALL place the per-cycle iteration datapath (one add/shift or subtract/shift step, XLEN-parametrised) in a sub-module mdu_step; control and sign fixup remain in mdu_iter.

Verification (XLEN=32)
REQ-030 SHALL cover: MUL op_a=7, op_b=0xFFFFFFFD accepted at edge 0 -> out_valid after edge 33, result 0xFFFFFFEB; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-031 SHALL cover: DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 7/2 -> 3.
REQ-032 SHALL cover: DIVU 5/0 -> 0xFFFFFFFF with out_valid after edge 1; REM 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same -> 0.
REQ-033 SHALL cover: flush at edge 10 of a MUL -> IDLE after edge 10, out_valid never rises, and a new request accepted at edge 11 completes correctly.
REQ-034 SHALL cover: out_ready held 0 for 5 cycles in DONE -> result and out_valid stable, in_ready 0; rst_n pulsed low mid-CALC -> outputs at reset values immediately, no stale result.
